// File: rtl/divider64b_pkg.sv
// Shared constants, state encoding and helpers for the 64-bit iterative divider.
package divider64b_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ITERS = 64;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

endpackage

// File: rtl/adder64b.sv
// 64-bit adder/subtractor; with sub=1, c_o=1 means a >= b (no borrow).
module adder64b
    import divider64b_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum_c,
    output logic            c_o
);

    logic [XLEN-1:0] b_eff;

    assign b_eff        = sub ? ~b : b;
    assign {c_o, sum_c} = {1'b0, a} + {1'b0, b_eff} + (XLEN + 1)'(sub);

endmodule

// File: rtl/divider64b.sv
// Iterative restoring divider: one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU results.
module divider64b
    import divider64b_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [XLEN-1:0]   rem, rem_n;
    logic [XLEN-1:0]   dvd, dvd_n;
    logic [XLEN-1:0]   dvs, dvs_n;
    logic              neg_q, neg_q_n;
    logic              neg_r, neg_r_n;
    logic [XLEN-1:0]   q_n, r_n;
    logic              busy_n, done_n;

    logic [XLEN:0]     shifted_c;
    logic [XLEN-1:0]   diff_c;
    logic              no_borrow_c;
    logic              accept_c;
    logic              a_neg_c, b_neg_c;
    logic              overflow_c;

    // Dividend bits leave dvd from the top while quotient bits fill in from the bottom.
    assign shifted_c = {rem, dvd[XLEN-1]};

    adder64b u_trial_sub (
        .a     (shifted_c[XLEN-1:0]),
        .b     (dvs),
        .sub   (1'b1),
        .sum_c (diff_c),
        .c_o   (no_borrow_c)
    );

    assign accept_c   = shifted_c[XLEN] | no_borrow_c;
    assign a_neg_c    = is_signed & a[XLEN-1];
    assign b_neg_c    = is_signed & b[XLEN-1];
    assign overflow_c = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        dvd_n   = dvd;
        dvs_n   = dvs;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        q_n     = q;
        r_n     = r;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    neg_q_n = a_neg_c ^ b_neg_c;
                    neg_r_n = a_neg_c;
                    dvd_n   = a_neg_c ? twos_neg(a) : a;
                    dvs_n   = b_neg_c ? twos_neg(b) : b;
                    rem_n   = '0;
                    cnt_n   = '0;
                    if (b == '0) begin
                        q_n     = '1;
                        r_n     = a;
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else if (overflow_c) begin
                        q_n     = a;
                        r_n     = '0;
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
                end
            end

            RUN: begin
                busy_n = 1'b1;
                rem_n  = accept_c ? diff_c : shifted_c[XLEN-1:0];
                dvd_n  = {dvd[XLEN-2:0], accept_c};
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITERS - 1)) begin
                    state_n = FIX;
                end
            end

            FIX: begin
                q_n     = neg_q ? twos_neg(dvd) : dvd;
                r_n     = neg_r ? twos_neg(rem) : rem;
                state_n = DONE;
                done_n  = 1'b1;
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            dvd   <= dvd_n;
            dvs   <= dvs_n;
            neg_q <= neg_q_n;
            neg_r <= neg_r_n;
            q     <= q_n;
            r     <= r_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule
